sw_arb: RTL and testbench
=========================

Name: sw_arb

Overview:
Output-port allocator for the 4-port wormhole packet switch (10-bit flits: [9:8] type 10=head, 01=body, 11=tail, 00=idle; head [1:0] = destination port).
- Sits between the four input FIFOs and the crossbar.
- Arbitrates head flits per output port with round-robin fairness.
- Holds each grant until the tail flit passes, then drives crossbar selects and FIFO pops.

Parameters:
PKTW, 9, MSB index of a flit (flit width PKTW+1).
NPORT, 4, number of ports. Fixed at 4; select/owner width is 2 bits.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
f0..f3  in  PKTW+1  head-of-FIFO flit of input i
v0..v3  in  1  input FIFO i non-empty (fi valid)
rdy0..rdy3  in  1  output port d can accept a flit this cycle
deq0..deq3  out  1  pop input FIFO i this cycle
sel0..sel3  out  2  crossbar source select for output d
ovld0..ovld3  out  1  output d carries a valid flit this cycle
err  out  4  per-input protocol-error pulse, registered, 1 cycle

Behaviour:
- Per-output state: IDLE/BUSY, owner[1:0], rr[1:0].
- Reset (rst low, async): all outputs IDLE, owner=0, rr=0, err=0. While rst is low, deq/sel/ovld are forced to 0.
- Input i is "free" when it owns no output.
- Request: free input i requests output d when vi=1, fi[9:8]=10 and fi[1:0]=d.
- Grant (combinational, same cycle) for output d in IDLE with rdyd=1:
  - Winner is the first requester scanning from rr_d upward, mod 4.
  - Outputs: deq_winner=1, sel_d=winner, ovld_d=1. The head flit passes in the grant cycle.
  - At the edge: BUSY, owner_d<=winner, rr_d<=winner+1 mod 4.
- IDLE with rdyd=0, or no requester: no grant; rr unchanged.
- BUSY, owner o: if vo=1, rdyd=1 and fo[9:8] is 01 or 11:
  - deq_o=1, sel_d=o, ovld_d=1.
  - On 11 (tail), next state is IDLE.
  - The output can grant again in the cycle after the tail. This gives zero-bubble back-to-back packets.
- BUSY with vo=0 or rdyd=0: stall. ovld_d=0, deq_o=0, sel_d holds owner.
- Protocol errors:
  - Owner presents type 10 or 00: output releases to IDLE; err[o] pulses next cycle; flit NOT dequeued (it re-arbitrates as a new head).
  - Free input presents valid type 01/11/00: flit is discarded (deq_i=1, no ovld); err[i] pulses next cycle.
- Each input requests at most one output, so deq_i is one-hot per input. Different outputs may grant different inputs in the same cycle.
- sel_d=0 when IDLE with no grant.
- Head source field [7:4] is ignored.
- Reset mid-packet: all grants drop immediately. The remainder of a packet then arrives at a free input and is discarded with err.

Test Plan:
- Reset: rst=0 with all vi=1 and heads present -> deq/ovld/sel/err all 0. Release rst -> grants begin the first cycle after release.
- Single packet: f0 = 10_0000_0001, then 01, 01, 11 on consecutive cycles, rdy1=1 -> ovld1=1 and sel1=0 for 4 cycles, deq0=1 each cycle; output 1 returns to IDLE after the tail.
- 4-way conflict, length 4, all to port 1 from reset:
  - Grant order is inputs 0,1,2,3 at cycles N, N+4, N+8, N+12.
  - ovld1 is continuously high for 16 cycles.
  - Each input's deq pulses only during its own window.
- Short-packet conflict (head+tail), all to port 0 from reset -> order 0,1,2,3, 2 cycles each. Follow with all to port 2 -> output 2 rr starts at 0 (rr is per output).
- Parallel and backpressure:
  - 0->2 and 1->3 simultaneously -> both granted in the same cycle.
  - rdy2=0 for 2 cycles mid-packet -> ovld2=0 and deq0=0 for those cycles; no flit lost; output 2 remains owned by input 0.
- Errors:
  - Owner 0 presents a new head mid-packet -> output released; err[0] pulses; that head is re-granted the next cycle.
  - Free input 3 presents 01_0011_0000 -> deq3=1, no ovld, err[3] pulses.

Source files
------------

// File: rtl/sw_arb_if.sv
// Interface between the input FIFOs / crossbar and the sw_arb output-port allocator.
// The slave modport is the allocator side; the master modport is the FIFO/crossbar side.
interface sw_arb_if #(
  parameter int PKTW = 9
);
  logic [PKTW:0] f0, f1, f2, f3;
  logic          v0, v1, v2, v3;
  logic          rdy0, rdy1, rdy2, rdy3;
  logic          deq0, deq1, deq2, deq3;
  logic [1:0]    sel0, sel1, sel2, sel3;
  logic          ovld0, ovld1, ovld2, ovld3;
  logic [3:0]    err;

  modport master (
    output f0, f1, f2, f3,
    output v0, v1, v2, v3,
    output rdy0, rdy1, rdy2, rdy3,
    input  deq0, deq1, deq2, deq3,
    input  sel0, sel1, sel2, sel3,
    input  ovld0, ovld1, ovld2, ovld3,
    input  err
  );

  modport slave (
    input  f0, f1, f2, f3,
    input  v0, v1, v2, v3,
    input  rdy0, rdy1, rdy2, rdy3,
    output deq0, deq1, deq2, deq3,
    output sel0, sel1, sel2, sel3,
    output ovld0, ovld1, ovld2, ovld3,
    output err
  );
endinterface

// File: rtl/sw_arb.sv
// Round-robin output-port allocator for a 4-port wormhole switch.
// Each output holds its grant from head to tail and drives crossbar select and FIFO pops.
module sw_arb #(
  parameter int PKTW  = 9,
  parameter int NPORT = 4
) (
  input logic     clk,
  input logic     rst,
  sw_arb_if.slave io_bus
);

  localparam logic [1:0] TYPE_BODY = 2'b01;
  localparam logic [1:0] TYPE_HEAD = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state [NPORT];
  logic [1:0]       r_owner [NPORT];
  logic [1:0]       r_rr    [NPORT];
  logic [NPORT-1:0] r_err;

  state_t           w_stateNext [NPORT];
  logic [1:0]       w_ownerNext [NPORT];
  logic [1:0]       w_rrNext    [NPORT];
  logic [PKTW:0]    w_f         [NPORT];
  logic [1:0]       w_sel       [NPORT];
  logic [NPORT-1:0] w_req       [NPORT];
  logic [NPORT-1:0] w_v, w_rdy, w_owns, w_deq, w_ovld, w_errNext;
  logic             w_found;
  logic [1:0]       w_win, w_idx, w_o, w_typ;
  logic             w_unused;

  assign w_f[0] = io_bus.f0;
  assign w_f[1] = io_bus.f1;
  assign w_f[2] = io_bus.f2;
  assign w_f[3] = io_bus.f3;
  assign w_v    = {io_bus.v3, io_bus.v2, io_bus.v1, io_bus.v0};
  assign w_rdy  = {io_bus.rdy3, io_bus.rdy2, io_bus.rdy1, io_bus.rdy0};

  // Outputs are held at zero for as long as reset is asserted.
  assign io_bus.deq0  = rst & w_deq[0];
  assign io_bus.deq1  = rst & w_deq[1];
  assign io_bus.deq2  = rst & w_deq[2];
  assign io_bus.deq3  = rst & w_deq[3];
  assign io_bus.ovld0 = rst & w_ovld[0];
  assign io_bus.ovld1 = rst & w_ovld[1];
  assign io_bus.ovld2 = rst & w_ovld[2];
  assign io_bus.ovld3 = rst & w_ovld[3];
  assign io_bus.sel0  = rst ? w_sel[0] : 2'b00;
  assign io_bus.sel1  = rst ? w_sel[1] : 2'b00;
  assign io_bus.sel2  = rst ? w_sel[2] : 2'b00;
  assign io_bus.sel3  = rst ? w_sel[3] : 2'b00;
  assign io_bus.err   = r_err;

  always_comb begin
    w_unused = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      w_unused = w_unused ^ (^w_f[i][PKTW-2:2]);
    end
  end

  // An input may request only while it owns no output.
  always_comb begin
    w_owns = '0;
    for (int d = 0; d < NPORT; d++) begin
      w_req[d] = '0;
      if (r_state[d] == ST_BUSY) begin
        w_owns[r_owner[d]] = 1'b1;
      end
    end
    for (int d = 0; d < NPORT; d++) begin
      for (int i = 0; i < NPORT; i++) begin
        w_req[d][i] = !w_owns[i] && w_v[i] &&
                      (w_f[i][PKTW -: 2] == TYPE_HEAD) &&
                      (w_f[i][1:0] == 2'(d));
      end
    end
  end

  always_comb begin
    w_deq     = '0;
    w_ovld    = '0;
    w_errNext = '0;
    w_found   = 1'b0;
    w_win     = '0;
    w_idx     = '0;
    w_o       = '0;
    w_typ     = '0;
    for (int d = 0; d < NPORT; d++) begin
      w_sel[d]       = '0;
      w_stateNext[d] = r_state[d];
      w_ownerNext[d] = r_owner[d];
      w_rrNext[d]    = r_rr[d];
    end

    for (int d = 0; d < NPORT; d++) begin
      case (r_state[d])
        ST_IDLE: begin
          w_found = 1'b0;
          w_win   = '0;
          for (int k = 0; k < NPORT; k++) begin
            w_idx = r_rr[d] + 2'(k);
            if (!w_found && w_req[d][w_idx]) begin
              w_found = 1'b1;
              w_win   = w_idx;
            end
          end
          if (w_found && w_rdy[d]) begin
            w_deq[w_win]   = 1'b1;
            w_ovld[d]      = 1'b1;
            w_sel[d]       = w_win;
            w_stateNext[d] = ST_BUSY;
            w_ownerNext[d] = w_win;
            w_rrNext[d]    = w_win + 2'd1;
          end
        end
        ST_BUSY: begin
          w_o      = r_owner[d];
          w_typ    = w_f[w_o][PKTW -: 2];
          w_sel[d] = w_o;
          if (w_v[w_o]) begin
            if (w_typ == TYPE_BODY || w_typ == TYPE_TAIL) begin
              if (w_rdy[d]) begin
                w_deq[w_o] = 1'b1;
                w_ovld[d]  = 1'b1;
                if (w_typ == TYPE_TAIL) begin
                  w_stateNext[d] = ST_IDLE;
                end
              end
            end else begin
              // Head or idle from an owner: drop the grant, keep the flit for re-arbitration.
              w_stateNext[d]   = ST_IDLE;
              w_errNext[w_o]   = 1'b1;
            end
          end
        end
        default: begin
          w_stateNext[d] = ST_IDLE;
        end
      endcase
    end

    for (int i = 0; i < NPORT; i++) begin
      if (w_v[i] && !w_owns[i] && (w_f[i][PKTW -: 2] != TYPE_HEAD)) begin
        w_deq[i]     = 1'b1;
        w_errNext[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < NPORT; d++) begin
        r_state[d] <= ST_IDLE;
        r_owner[d] <= '0;
        r_rr[d]    <= '0;
      end
      r_err <= '0;
    end else begin
      for (int d = 0; d < NPORT; d++) begin
        r_state[d] <= w_stateNext[d];
        r_owner[d] <= w_ownerNext[d];
        r_rr[d]    <= w_rrNext[d];
      end
      r_err <= w_errNext;
    end
  end

endmodule

// File: tb/tb_sw_arb.sv
// Scoreboard bench for sw_arb: input FIFOs are modelled as queues, expected
// per-cycle activity is queued by the stimulus and popped by an independent monitor.
module tb_sw_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sw_arb_if #(.PKTW(9)) bus();

  sw_arb #(.PKTW(9), .NPORT(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  logic [9:0] tbF [4];
  logic [3:0] tbV;
  logic [3:0] tbRdy;

  assign bus.f0   = tbF[0];
  assign bus.f1   = tbF[1];
  assign bus.f2   = tbF[2];
  assign bus.f3   = tbF[3];
  assign bus.v0   = tbV[0];
  assign bus.v1   = tbV[1];
  assign bus.v2   = tbV[2];
  assign bus.v3   = tbV[3];
  assign bus.rdy0 = tbRdy[0];
  assign bus.rdy1 = tbRdy[1];
  assign bus.rdy2 = tbRdy[2];
  assign bus.rdy3 = tbRdy[3];

  wire [3:0] deqVec  = {bus.deq3, bus.deq2, bus.deq1, bus.deq0};
  wire [3:0] ovldVec = {bus.ovld3, bus.ovld2, bus.ovld1, bus.ovld0};
  wire [7:0] selVec  = {bus.sel3, bus.sel2, bus.sel1, bus.sel0};
  wire [3:0] errVec  = bus.err;

  typedef struct {
    int         cyc;
    logic [3:0] ovld;
    logic [3:0] deq;
    logic [7:0] sel;
    logic [3:0] err;
  } exp_t;

  exp_t       expQ [$];
  exp_t       monE;
  logic [9:0] fifo [4][$];
  int         cyc;
  int         base;
  int         checks;
  int         failures;
  logic [3:0] deqLatch;

  function automatic logic [9:0] head(input logic [3:0] src, input logic [1:0] dst);
    return {2'b10, src, 2'b00, dst};
  endfunction

  function automatic logic [9:0] body(input logic [7:0] data);
    return {2'b01, data};
  endfunction

  function automatic logic [9:0] tail(input logic [7:0] data);
    return {2'b11, data};
  endfunction

  function automatic void pushExp(input int c, input logic [3:0] ov, input logic [3:0] dq,
                                  input logic [7:0] sl, input logic [3:0] er);
    exp_t e;
    e.cyc  = c;
    e.ovld = ov;
    e.deq  = dq;
    e.sel  = sl;
    e.err  = er;
    expQ.push_back(e);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      tbV[i] = (fifo[i].size() != 0);
      tbF[i] = (fifo[i].size() != 0) ? fifo[i][0] : 10'h000;
    end
  endtask

  // Drives rdy for the current cycle, then pops whatever the DUT dequeued at the edge.
  task automatic applyStimulus(input logic [3:0] rdyVec);
    tbRdy = rdyVec;
    @(negedge clk);
    deqLatch = deqVec;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (deqLatch[i] && fifo[i].size() != 0) begin
        void'(fifo[i].pop_front());
      end
    end
    #1;
    refresh();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && (ovldVec != 4'b0 || deqVec != 4'b0 || errVec != 4'b0)) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_activity cyc=%0d actual ovld=%b deq=%b err=%b required none",
                 cyc, ovldVec, deqVec, errVec);
      end else begin
        monE = expQ.pop_front();
        checkOutput("cycle", cyc, monE.cyc);
        checkOutput("ovld", int'(ovldVec), int'(monE.ovld));
        checkOutput("deq", int'(deqVec), int'(monE.deq));
        checkOutput("sel", int'(selVec), int'(monE.sel));
        checkOutput("err", int'(errVec), int'(monE.err));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    base     = 0;
    deqLatch = '0;
    tbRdy    = '0;
    tbV      = '0;
    for (int i = 0; i < 4; i++) tbF[i] = '0;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Four length-4 packets all to port 1, loaded while reset is held.
    for (int i = 0; i < 4; i++) begin
      fifo[i].push_back(head(4'(i), 2'd1));
      fifo[i].push_back(body(8'h11));
      fifo[i].push_back(body(8'h22));
      fifo[i].push_back(tail(8'h33));
    end
    refresh();
    tbRdy = 4'hF;
    @(negedge clk);
    checkOutput("reset_deq", int'(deqVec), 0);
    checkOutput("reset_ovld", int'(ovldVec), 0);
    checkOutput("reset_sel", int'(selVec), 0);
    checkOutput("reset_err", int'(errVec), 0);
    @(posedge clk);
    cyc++;
    #1;
    rst  = 1'b1;
    base = cyc;
    for (int k = 0; k < 16; k++) begin
      pushExp(base + k, 4'b0010, 4'(1 << (k / 4)), 8'((k / 4) << 2), 4'b0000);
    end
    for (int k = 0; k < 18; k++) applyStimulus(4'hF);

    // Short packets to port 0 after a fresh reset.
    rst = 1'b0;
    applyStimulus(4'hF);
    for (int i = 0; i < 4; i++) begin
      fifo[i].push_back(head(4'(i), 2'd0));
      fifo[i].push_back(tail(8'h5A));
    end
    refresh();
    rst  = 1'b1;
    base = cyc;
    for (int k = 0; k < 8; k++) begin
      pushExp(base + k, 4'b0001, 4'(1 << (k / 2)), 8'(k / 2), 4'b0000);
    end
    for (int k = 0; k < 10; k++) applyStimulus(4'hF);

    // Same pattern to port 2: its pointer starts at 0 on its own.
    for (int i = 0; i < 4; i++) begin
      fifo[i].push_back(head(4'(i), 2'd2));
      fifo[i].push_back(tail(8'hA5));
    end
    refresh();
    base = cyc;
    for (int k = 0; k < 8; k++) begin
      pushExp(base + k, 4'b0100, 4'(1 << (k / 2)), 8'((k / 2) << 4), 4'b0000);
    end
    for (int k = 0; k < 10; k++) applyStimulus(4'hF);

    // Parallel 0->2 and 1->3, with port 2 stalled for two cycles mid-packet.
    fifo[0].push_back(head(4'd0, 2'd2));
    fifo[0].push_back(body(8'h01));
    fifo[0].push_back(body(8'h02));
    fifo[0].push_back(tail(8'h03));
    fifo[1].push_back(head(4'd1, 2'd3));
    fifo[1].push_back(body(8'h04));
    fifo[1].push_back(tail(8'h05));
    refresh();
    base = cyc;
    pushExp(base + 0, 4'b1100, 4'b0011, 8'h40, 4'b0000);
    pushExp(base + 1, 4'b1100, 4'b0011, 8'h40, 4'b0000);
    pushExp(base + 2, 4'b1000, 4'b0010, 8'h40, 4'b0000);
    pushExp(base + 4, 4'b0100, 4'b0001, 8'h00, 4'b0000);
    pushExp(base + 5, 4'b0100, 4'b0001, 8'h00, 4'b0000);
    for (int k = 0; k < 8; k++) applyStimulus((k == 2 || k == 3) ? 4'b1011 : 4'b1111);

    // Idle port 0 not ready: no grant until rdy0 rises.
    fifo[2].push_back(head(4'd2, 2'd0));
    fifo[2].push_back(tail(8'h77));
    refresh();
    base = cyc;
    pushExp(base + 2, 4'b0001, 4'b0100, 8'h02, 4'b0000);
    pushExp(base + 3, 4'b0001, 4'b0100, 8'h02, 4'b0000);
    for (int k = 0; k < 6; k++) applyStimulus((k < 2) ? 4'b1110 : 4'b1111);

    // Owner 0 presents a new head mid-packet on port 1.
    fifo[0].push_back(head(4'd0, 2'd1));
    fifo[0].push_back(body(8'h10));
    fifo[0].push_back(head(4'd0, 2'd1));
    fifo[0].push_back(body(8'h20));
    fifo[0].push_back(tail(8'h30));
    refresh();
    base = cyc;
    pushExp(base + 0, 4'b0010, 4'b0001, 8'h00, 4'b0000);
    pushExp(base + 1, 4'b0010, 4'b0001, 8'h00, 4'b0000);
    pushExp(base + 3, 4'b0010, 4'b0001, 8'h00, 4'b0001);
    pushExp(base + 4, 4'b0010, 4'b0001, 8'h00, 4'b0000);
    pushExp(base + 5, 4'b0010, 4'b0001, 8'h00, 4'b0000);
    for (int k = 0; k < 8; k++) applyStimulus(4'hF);

    // Stray body flit at free input 3 is discarded with an error.
    fifo[3].push_back(10'h130);
    refresh();
    base = cyc;
    pushExp(base + 0, 4'b0000, 4'b1000, 8'h00, 4'b0000);
    pushExp(base + 1, 4'b0000, 4'b0000, 8'h00, 4'b1000);
    for (int k = 0; k < 4; k++) applyStimulus(4'hF);

    applyStimulus(4'hF);
    applyStimulus(4'hF);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
